// File: rtl/extensor_inmediato_pipe_pkg.sv
// Shared constants for the immediate generator: format selector encodings
// and the occupancy type/values used by the output skid buffer.
package pkg_inmediato;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] IMM_I  = 3'd0;
  localparam logic [SEL_W-1:0] IMM_S  = 3'd1;
  localparam logic [SEL_W-1:0] IMM_B  = 3'd2;
  localparam logic [SEL_W-1:0] IMM_U  = 3'd3;
  localparam logic [SEL_W-1:0] IMM_J  = 3'd4;
  localparam logic [SEL_W-1:0] IMM_Z  = 3'd5;
  localparam logic [SEL_W-1:0] IMM_SH = 3'd6;

  typedef logic [1:0] ocupacion_t;

  localparam ocupacion_t OCC_EMPTY = 2'd0;
  localparam ocupacion_t OCC_ONE   = 2'd1;
  localparam ocupacion_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/extensor_inmediato_pipe_buffer_salida.sv
// Generic 2-entry valid/ready skid FIFO, head is always entry 0.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready depends only on the registered count (and rst), never on out_ready.
module buffer_salida
  import pkg_inmediato::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);

  ocupacion_t   count;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         push;
  logic         pop;

  assign in_ready  = !rst && (count != OCC_FULL);
  assign out_valid = (count != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dout      = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= OCC_EMPTY;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case (count)
        OCC_EMPTY: begin
          if (push) begin
            ent0  <= din;
            count <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Push and pop together: the new item simply replaces the head.
          if (push && pop) begin
            ent0 <= din;
          end else if (push) begin
            ent1  <= din;
            count <= OCC_FULL;
          end else if (pop) begin
            count <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            ent0  <= ent1;
            count <= OCC_ONE;
          end
        end
        default: count <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/extensor_inmediato_pipe.sv
// Registered immediate generator: decodes the format, extends to XLEN, buffers {imm, imm_err}.
// Latency: 1 cycle; throughput 1 item/cycle while out_ready is high.
// Backpressure: 2-entry skid buffer; in_ready drops only when both entries are held.
module extensor_inmediato_pipe
  import pkg_inmediato::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  instr,
  input  logic [SEL_W-1:0] imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic             imm_err
);

  logic [31:0]     campo;
  logic            err;
  logic [XLEN-1:0] imm_ext;
  logic            unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // campo is already correct to 32 bits; bit 31 is the sign for every format
  // (zero for Z/SH/illegal), so one signed widening covers XLEN > 32.
  always_comb begin
    campo = '0;
    err   = 1'b0;
    case (imm_src)
      IMM_I:   campo = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   campo = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   campo = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   campo = {instr[31:12], 12'b0};
      IMM_J:   campo = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   campo = {27'b0, instr[19:15]};
      IMM_SH:  campo = {27'b0, instr[24:20]};
      default: begin
        campo = '0;
        err   = 1'b1;
      end
    endcase
  end

  assign imm_ext = XLEN'($signed(campo));

  buffer_salida #(
    .W(XLEN + 1)
  ) u_buffer_salida (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      ({imm_ext, err}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     ({imm, imm_err})
  );

endmodule
